// File: rtl/cpu_ctrl_pkg.sv
// Shared types and widths for the CPU pipeline control blocks.
package cpu_ctrl_pkg;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [2:0] {
    RUN,
    MEM_WAIT,
    INT_DRAIN,
    INT_ENTER,
    INT_ACTIVE
  } hz_state_t;
endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive data-memory busy cycles and emits one pulse when the
// limit is reached; the count saturates until busy drops.
module mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_busy,
  output logic o_timeout
);
  localparam logic [7:0] LP_LIMIT = 8'(MEM_TIMEOUT);
  localparam logic [7:0] LP_PULSE = 8'(MEM_TIMEOUT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (!i_busy) begin
      r_cnt <= 8'd0;
    end else if (r_cnt != LP_LIMIT) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Pulse on the busy cycle that takes the count to the limit.
  assign o_timeout = i_busy && (r_cnt == LP_PULSE);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall/flush generation for load-use, branch redirect,
// data-memory wait and interrupt entry, plus a memory-wait watchdog.
//
// state      | meaning
// RUN        | normal flow; branch/load-use handling; interrupts accepted
// MEM_WAIT   | dmem busy, whole pipe held; r_ret_state resumes afterwards
// INT_DRAIN  | PC held, IF/ID flushed while front end empties
// INT_ENTER  | one cycle interrupt injection and acknowledge
// INT_ACTIVE | as RUN but interrupts masked until returni reaches EX
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_reg_dst,
  input  logic                  ex_reg_wr,
  input  logic                  ex_wb_sel,
  input  logic                  branch_taken,
  input  logic                  returni_ex,
  input  logic                  dmem_busy,
  input  logic                  interrupt_req,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  stall_id_ex,
  output logic                  flush_id_ex,
  output logic                  stall_ex_mem,
  output logic                  int_inject,
  output logic                  int_ack,
  output logic                  mem_timeout
);
  hz_state_t  r_state, r_ret_state;
  hz_state_t  w_state_nxt, w_ret_nxt, w_eff_state;
  logic [3:0] r_drain_cnt, w_drain_nxt;
  logic       w_lu, w_timeout;
  logic       w_stall_pc, w_stall_if_id, w_flush_if_id, w_stall_id_ex;
  logic       w_flush_id_ex, w_stall_ex_mem, w_int_inject, w_int_ack;

  assign w_lu = ex_reg_wr && ex_wb_sel &&
                ((id_rs1_used && (id_rs1 == ex_reg_dst)) ||
                 (id_rs2_used && (id_rs2 == ex_reg_dst)));

  // Once busy drops, the saved state takes effect in the same cycle.
  assign w_eff_state = (r_state == MEM_WAIT) ? r_ret_state : r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_ret_state <= RUN;
      r_drain_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ret_nxt      = r_ret_state;
    w_drain_nxt    = r_drain_cnt;
    w_stall_pc     = 1'b0;
    w_stall_if_id  = 1'b0;
    w_flush_if_id  = 1'b0;
    w_stall_id_ex  = 1'b0;
    w_flush_id_ex  = 1'b0;
    w_stall_ex_mem = 1'b0;
    w_int_inject   = 1'b0;
    w_int_ack      = 1'b0;
    if (dmem_busy) begin
      w_stall_pc     = 1'b1;
      w_stall_if_id  = 1'b1;
      w_stall_id_ex  = 1'b1;
      w_stall_ex_mem = 1'b1;
      w_state_nxt    = MEM_WAIT;
      w_ret_nxt      = w_eff_state;
    end else begin
      w_state_nxt = w_eff_state;
      case (w_eff_state)
        RUN, INT_ACTIVE: begin
          if (branch_taken) begin
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
          end else if (w_lu) begin
            w_stall_pc    = 1'b1;
            w_stall_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
          end else if ((w_eff_state == RUN) && interrupt_req) begin
            w_state_nxt = INT_DRAIN;
            w_drain_nxt = 4'(DRAIN_CYCLES);
          end
          if ((w_eff_state == INT_ACTIVE) && returni_ex) begin
            w_state_nxt = RUN;
          end
        end
        INT_DRAIN: begin
          w_stall_pc    = 1'b1;
          w_flush_if_id = 1'b1;
          w_flush_id_ex = branch_taken;
          if (r_drain_cnt <= 4'd1) begin
            w_state_nxt = INT_ENTER;
            w_drain_nxt = 4'd0;
          end else begin
            w_drain_nxt = r_drain_cnt - 4'd1;
          end
        end
        INT_ENTER: begin
          w_stall_pc    = 1'b1;
          w_flush_if_id = 1'b1;
          w_int_inject  = 1'b1;
          w_int_ack     = 1'b1;
          w_state_nxt   = INT_ACTIVE;
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_busy   (dmem_busy),
    .o_timeout(w_timeout)
  );

  // Outputs are forced low while reset is asserted, whatever the inputs.
  assign stall_pc     = rst_n && w_stall_pc;
  assign stall_if_id  = rst_n && w_stall_if_id;
  assign flush_if_id  = rst_n && w_flush_if_id;
  assign stall_id_ex  = rst_n && w_stall_id_ex;
  assign flush_id_ex  = rst_n && w_flush_id_ex;
  assign stall_ex_mem = rst_n && w_stall_ex_mem;
  assign int_inject   = rst_n && w_int_inject;
  assign int_ack      = rst_n && w_int_ack;
  assign mem_timeout  = rst_n && w_timeout;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int DRAIN = 3;
  localparam int TMO   = 64;

  // Output vector order: {stall_pc, stall_if_id, flush_if_id, stall_id_ex,
  //                       flush_id_ex, stall_ex_mem, int_inject, int_ack, mem_timeout}
  localparam logic [8:0] E_NONE  = 9'b000000000;
  localparam logic [8:0] E_LU    = 9'b110010000;
  localparam logic [8:0] E_BR    = 9'b001010000;
  localparam logic [8:0] E_BUSY  = 9'b110101000;
  localparam logic [8:0] E_DRAIN = 9'b101000000;
  localparam logic [8:0] E_ENTER = 9'b101000110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] id_rs1 = '0, id_rs2 = '0, ex_reg_dst = '0;
  logic       id_rs1_used = 0, id_rs2_used = 0, ex_reg_wr = 0, ex_wb_sel = 0;
  logic       branch_taken = 0, returni_ex = 0, dmem_busy = 0, interrupt_req = 0;
  logic       stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex;
  logic       stall_ex_mem, int_inject, int_ack, mem_timeout;

  int total = 0;
  int bad = 0;
  logic [8:0] last_dut;

  // Reference model: interrupt phase (0 normal, 1 draining, 2 entering,
  // 3 handler running), drain cycles left, and length of current busy run.
  int m_phase = 0;
  int m_drain_left = 0;
  int m_busy_run = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_reg_dst(ex_reg_dst), .ex_reg_wr(ex_reg_wr), .ex_wb_sel(ex_wb_sel),
    .branch_taken(branch_taken), .returni_ex(returni_ex),
    .dmem_busy(dmem_busy), .interrupt_req(interrupt_req),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
    .stall_id_ex(stall_id_ex), .flush_id_ex(flush_id_ex),
    .stall_ex_mem(stall_ex_mem), .int_inject(int_inject), .int_ack(int_ack),
    .mem_timeout(mem_timeout)
  );

  typedef struct {
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       u1;
    logic       u2;
    logic [3:0] dst;
    logic       wr;
    logic       wbsel;
    logic       br;
    logic       reti;
    logic       busy;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [8:0] dut_vec();
    return {stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
            stall_ex_mem, int_inject, int_ack, mem_timeout};
  endfunction

  task automatic chk_vec(input string name, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_drain_left = 0;
    m_busy_run = 0;
  endtask

  task automatic model_step(output logic [8:0] exp);
    logic sp, sif, fif, sie, fie, sem, inj, ack, tmo, lu;
    {sp, sif, fif, sie, fie, sem, inj, ack, tmo} = '0;
    lu = ex_reg_wr && ex_wb_sel &&
         ((id_rs1_used && id_rs1 == ex_reg_dst) || (id_rs2_used && id_rs2 == ex_reg_dst));
    if (dmem_busy) begin
      {sp, sif, sie, sem} = 4'b1111;
      m_busy_run++;
      tmo = (m_busy_run == TMO);
    end else begin
      m_busy_run = 0;
      case (m_phase)
        0, 3: begin
          if (branch_taken) begin
            fif = 1; fie = 1;
          end else if (lu) begin
            sp = 1; sif = 1; fie = 1;
          end else if (m_phase == 0 && interrupt_req) begin
            m_phase = 1;
            m_drain_left = DRAIN;
          end
          if (m_phase == 3 && returni_ex) m_phase = 0;
        end
        1: begin
          sp = 1; fif = 1; fie = branch_taken;
          m_drain_left--;
          if (m_drain_left == 0) m_phase = 2;
        end
        default: begin
          sp = 1; fif = 1; inj = 1; ack = 1;
          m_phase = 3;
        end
      endcase
    end
    exp = {sp, sif, fif, sie, fie, sem, inj, ack, tmo};
  endtask

  // One clock: inputs already driven. Compare at the falling edge against
  // either a fixed expectation or the model; the model always advances.
  task automatic run_cycle(input bit use_fixed, input logic [8:0] fixed, input string name);
    logic [8:0] mexp;
    @(negedge clk);
    model_step(mexp);
    last_dut = dut_vec();
    chk_vec(name, last_dut, use_fixed ? fixed : mexp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_reg_dst = 0; ex_reg_wr = 0; ex_wb_sel = 0;
    branch_taken = 0; returni_ex = 0; dmem_busy = 0; interrupt_req = 0;
  endtask

  task automatic set_lu5();
    ex_wb_sel = 1; ex_reg_wr = 1; ex_reg_dst = 5; id_rs2 = 5; id_rs2_used = 1;
  endtask

  int pulses, pulse_at, acks, drain_len;

  initial begin
    //            rs1 rs2 u1 u2 dst wr wb br rt busy exp
    tbl[0] = '{4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0, 0, E_NONE};
    tbl[1] = '{4'd0, 4'd5, 0, 1, 4'd5, 1, 1, 0, 0, 0, E_LU};
    tbl[2] = '{4'd0, 4'd5, 0, 1, 4'd5, 0, 0, 0, 0, 0, E_NONE};
    tbl[3] = '{4'd7, 4'd2, 0, 1, 4'd7, 1, 1, 0, 0, 0, E_NONE};
    tbl[4] = '{4'd7, 4'd2, 1, 1, 4'd7, 1, 0, 0, 0, 0, E_NONE};
    tbl[5] = '{4'd0, 4'd3, 1, 0, 4'd0, 1, 1, 0, 0, 0, E_LU};
    tbl[6] = '{4'd9, 4'd9, 1, 1, 4'd9, 1, 1, 1, 0, 0, E_BR};
    tbl[7] = '{4'd9, 4'd9, 1, 1, 4'd9, 1, 1, 1, 0, 1, E_BUSY};
    tbl[8] = '{4'd1, 4'd2, 1, 1, 4'd3, 1, 1, 0, 1, 0, E_NONE};

    idle_inputs();
    #12;
    chk_vec("reset_outputs", dut_vec(), E_NONE);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2;
      id_rs1_used = tbl[i].u1; id_rs2_used = tbl[i].u2;
      ex_reg_dst = tbl[i].dst; ex_reg_wr = tbl[i].wr; ex_wb_sel = tbl[i].wbsel;
      branch_taken = tbl[i].br; returni_ex = tbl[i].reti; dmem_busy = tbl[i].busy;
      interrupt_req = 0;
      run_cycle(1, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Load-use on rs2 gives exactly one bubble once EX holds the bubble.
    idle_inputs();
    set_lu5();
    run_cycle(1, E_LU, "lu_rs2");
    idle_inputs();
    run_cycle(1, E_NONE, "lu_after");

    // Long memory wait: stalls every cycle, single watchdog pulse at 64.
    idle_inputs();
    dmem_busy = 1;
    pulses = 0;
    pulse_at = 0;
    for (int i = 1; i <= 70; i++) begin
      run_cycle(0, E_NONE, "busy70");
      if (last_dut[0]) begin
        pulses++;
        pulse_at = i;
      end
    end
    chk_int("busy70_pulse_count", pulses, 1);
    chk_int("busy70_pulse_cycle", pulse_at, TMO);
    dmem_busy = 0;
    run_cycle(1, E_NONE, "busy70_release");

    // Interrupt entry, masking while active, re-accept after returni.
    interrupt_req = 1;
    run_cycle(1, E_NONE, "irq_accept");
    interrupt_req = 0;
    for (int i = 0; i < DRAIN; i++) run_cycle(1, E_DRAIN, "irq_drain");
    run_cycle(1, E_ENTER, "irq_enter");
    interrupt_req = 1;
    for (int i = 0; i < 3; i++) run_cycle(1, E_NONE, "irq_masked");
    branch_taken = 1;
    run_cycle(1, E_BR, "active_branch");
    branch_taken = 0;
    returni_ex = 1;
    run_cycle(1, E_NONE, "returni_cycle");
    returni_ex = 0;
    run_cycle(1, E_NONE, "irq_reaccept");
    interrupt_req = 0;
    run_cycle(1, E_DRAIN, "irq2_drain_start");
    for (int i = 1; i < DRAIN; i++) run_cycle(0, E_NONE, "irq2_drain");
    run_cycle(1, E_ENTER, "irq2_enter");
    returni_ex = 1;
    run_cycle(1, E_NONE, "irq2_returni");
    returni_ex = 0;

    // Busy during drain stretches it; acknowledge still a single pulse.
    interrupt_req = 1;
    run_cycle(1, E_NONE, "bd_accept");
    interrupt_req = 0;
    acks = 0;
    drain_len = 0;
    run_cycle(1, E_DRAIN, "bd_drain1");
    drain_len++;
    dmem_busy = 1;
    run_cycle(1, E_BUSY, "bd_busy1");
    drain_len++;
    run_cycle(1, E_BUSY, "bd_busy2");
    drain_len++;
    dmem_busy = 0;
    for (int i = 0; i < 2; i++) begin
      run_cycle(1, E_DRAIN, "bd_drain_rest");
      drain_len++;
    end
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, E_NONE, "bd_enter_window");
      if (last_dut[1]) acks++;
      if (i == 0) chk_vec("bd_enter", last_dut, E_ENTER);
    end
    chk_int("bd_drain_len", drain_len, DRAIN + 2);
    chk_int("bd_ack_count", acks, 1);
    returni_ex = 1;
    run_cycle(1, E_NONE, "bd_returni");
    returni_ex = 0;

    // Reset in the second drain cycle clears outputs at once.
    interrupt_req = 1;
    run_cycle(1, E_NONE, "rst_accept");
    interrupt_req = 0;
    run_cycle(1, E_DRAIN, "rst_drain1");
    interrupt_req = 1;
    dmem_busy = 1;
    rst_n = 0;
    #1;
    chk_vec("rst_mid_drain", dut_vec(), E_NONE);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk_vec("rst_held", dut_vec(), E_NONE);
    idle_inputs();
    rst_n = 1;
    @(posedge clk);
    #1;
    set_lu5();
    run_cycle(1, E_LU, "post_reset_run");
    idle_inputs();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      id_rs1 = 4'($urandom_range(0, 3));
      id_rs2 = 4'($urandom_range(0, 3));
      ex_reg_dst = 4'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      ex_reg_wr = 1'($urandom_range(0, 1));
      ex_wb_sel = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 99) < 15);
      returni_ex = ($urandom_range(0, 99) < 8);
      interrupt_req = ($urandom_range(0, 99) < 25);
      dmem_busy = ($urandom_range(0, 99) < 15);
      run_cycle(0, E_NONE, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
